bsg_mem_1rw_sync_mask_write_bit_arb: RTL
========================================

// Module: bsg_mem_1rw_sync_mask_write_bit_arb
// PURPOSE
//  Shares one bsg_mem_1rw_sync_mask_write_bit instance among num_req_p requesters.
//  - Round-robin arbitration; at most one memory access per cycle.
//  - Bit-masked writes complete silently; reads return tagged data through a credit-limited response queue.
//  - Optional post-reset clear sweep zeroes every word before requests are accepted.
//  - Sits between client ports and the RAM macro wrapper; owns all RAM control pins.
// PARAMETERS
//  width_p        (none)  data/mask width in bits, >=1
//  els_p          (none)  RAM depth in words, >=1
//  num_req_p      2       number of requesters, >=1
//  init_p         1       1: clear RAM after reset; 0: accept requests immediately
//  addr_width_lp  `BSG_SAFE_CLOG2(els_p)      derived
//  id_width_lp    `BSG_SAFE_CLOG2(num_req_p)  derived
// PORTS
//  clk_i         in   1                      clock, all logic on posedge
//  reset_n_i     in   1                      asynchronous, active-low reset
//  req_v_i       in   num_req_p              request valid, one bit per requester
//  req_ready_o   out  num_req_p              request accepted this cycle (v & ready = handshake)
//  req_w_i       in   num_req_p              1 = masked write, 0 = read
//  req_addr_i    in   num_req_p*addr_width   word address per requester
//  req_data_i    in   num_req_p*width_p      write data per requester
//  req_mask_i    in   num_req_p*width_p      per-bit write enable per requester
//  resp_v_o      out  1                      read response valid
//  resp_id_o     out  id_width_lp            requester index of response
//  resp_data_o   out  width_p                read data
//  resp_ready_i  in   1                      consumer accepts response
//  init_done_o   out  1                      1 once clear sweep finished (or init_p=0)
//  mem_v_o, mem_w_o           out  1         RAM access valid / write
//  mem_addr_o                 out  addr_width_lp
//  mem_data_o, mem_w_mask_o   out  width_p
//  mem_data_i                 in   width_p   RAM read data, valid cycle after read
// BEHAVIOUR
//  - Reset: while reset_n_i=0 all outputs are 0.
//    - State, RR pointer, in-flight flag and response queue clear asynchronously.
//    - An in-flight read is discarded; no response is produced for it.
//  - FSM: eINIT -> eRUN.
//    - Exit from reset enters eINIT if init_p=1, else eRUN.
//    - eINIT: sweep counter 0..els_p-1, one write per cycle, data=0, mask=all-ones.
//      req_ready_o=0, init_done_o=0. After the write to els_p-1, go to eRUN next cycle.
//    - eRUN: init_done_o=1; remains until reset.
//  - Credits: cnt = queue occupancy + in-flight read (0..2); queue depth 2.
//  - Eligibility in eRUN: requester i is eligible if req_v_i[i] & (req_w_i[i] | cnt<2).
//    A read arriving when credits are short is skipped, not blocking.
//  - Grant: first eligible index at or after rr_ptr, wrapping modulo num_req_p.
//    - req_ready_o is one-hot on the winner, 0 elsewhere.
//    - rr_ptr <= winner+1 (wraps to 0 after num_req_p-1); unchanged when there is no grant.
//  - mem_v_o = grant valid; mem_w_o/addr/data/mask are the winner's fields. Combinational.
//  - Read grant at cycle t:
//    - mem_data_i is captured at t+1 into the queue with the winner's id.
//    - resp_v_o is asserted from t+2 (fixed 2-cycle latency when the queue is empty).
//  - Responses leave in issue order; each is held stable until resp_ready_i.
//  - Same-cycle dequeue frees its credit in that same cycle for eligibility.
//  - Back-to-back reads are sustained at 1 per cycle when resp_ready_i=1.
//  - Write-then-read to the same address on consecutive cycles returns the new data.
//  - Writes never wait on credits; a write with mask=0 still consumes the cycle.
//  - Addresses >= els_p: undefined contents; an assertion fires in simulation.
// STRUCTURE
//  - Package bsg_mem_arb_pkg: state_e {eINIT, eRUN}.
//  - Submodule bsg_two_fifo (width id_width_lp+width_p) as the response queue.
//  - Arbiter, credit counter, sweep counter and FSM live inline.
// TESTING
//  1. Reset release, init_p=1, els_p=16:
//     -> 16 cycles of mem_v_o=1, mem_w_o=1, addr 0..15, data 0;
//     -> init_done_o rises cycle 17; req_ready_o=0 throughout the sweep.
//  2. num_req_p=3, all assert reads every cycle, resp_ready_i=1:
//     -> grants 0,1,2,0,1,2...;
//     -> resp_id_o sequence matches, each 2 cycles after its grant.
//  3. Write addr 5 data 8'hFF mask 8'h0F, then write data 8'h00 mask 8'hF0, then read addr 5:
//     -> resp_data_o=8'h0F.
//  4. resp_ready_i=0, req 0 reads continuously:
//     -> exactly 2 grants, then req_ready_o[0]=0;
//     -> req 1 write still granted every cycle;
//     -> raising resp_ready_i drains id 0 data in order.
//  5. Assert reset_n_i low one cycle after a read grant:
//     -> no response appears after release;
//     -> outputs 0 during reset; sweep restarts.
//  6. init_p=0, els_p=1:
//     -> init_done_o=1 the first cycle after reset;
//     -> write then read of addr 0 returns the written data.

Source files
------------

// File: rtl/bsg_mem_arb_pkg.sv
// Shared types and helpers for the arbitrated 1rw masked-write RAM front end.
package bsg_mem_arb_pkg;

  typedef enum logic {
    eINIT = 1'b0,
    eRUN  = 1'b1
  } state_e;

  // Address/id width that stays >= 1 even for a single element.
  function automatic int safe_clog2(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/bsg_two_fifo.sv
// Two-entry response queue; data_o is the head entry while v_o is high.
module bsg_two_fifo #(
  parameter int width_p = 8
) (
  input  logic               clk_i,
  input  logic               reset_n_i,
  input  logic               v_i,
  input  logic [width_p-1:0] data_i,
  output logic               ready_o,
  output logic               v_o,
  output logic [width_p-1:0] data_o,
  input  logic               yumi_i
);

  logic [width_p-1:0] mem_r [2];
  logic               wptr_r;
  logic               rptr_r;
  logic               empty_r;
  logic               full_r;
  logic               enq;

  assign ready_o = ~full_r;
  assign v_o     = ~empty_r;
  assign data_o  = mem_r[rptr_r];
  assign enq     = v_i & ~full_r;

  // Storage, pointers and full/empty flags; enqueue and dequeue may coincide.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      mem_r[0] <= '0;
      mem_r[1] <= '0;
      wptr_r   <= 1'b0;
      rptr_r   <= 1'b0;
      empty_r  <= 1'b1;
      full_r   <= 1'b0;
    end else begin
      if (enq) begin
        mem_r[wptr_r] <= data_i;
        wptr_r        <= ~wptr_r;
      end
      if (yumi_i) begin
        rptr_r <= ~rptr_r;
      end
      if (enq && !yumi_i) begin
        empty_r <= 1'b0;
        full_r  <= (~wptr_r == rptr_r);
      end else if (yumi_i && !enq) begin
        full_r  <= 1'b0;
        empty_r <= (~rptr_r == wptr_r);
      end
    end
  end

endmodule

// File: rtl/bsg_mem_1rw_sync_mask_write_bit_arb.sv
// Round-robin front end sharing one synchronous 1rw bit-masked RAM among
// several requesters. Reads return tagged data through a 2-deep credited queue.
//
// state | meaning
// eINIT | post-reset sweep writes zero to every word, requests held off
// eRUN  | normal arbitration, init_done_o high
module bsg_mem_1rw_sync_mask_write_bit_arb
  import bsg_mem_arb_pkg::*;
#(
  parameter int width_p   = 8,
  parameter int els_p     = 16,
  parameter int num_req_p = 2,
  parameter int init_p    = 1,
  localparam int addr_width_lp = safe_clog2(els_p),
  localparam int id_width_lp   = safe_clog2(num_req_p)
) (
  input  logic                               clk_i,
  input  logic                               reset_n_i,
  input  logic [num_req_p-1:0]               req_v_i,
  output logic [num_req_p-1:0]               req_ready_o,
  input  logic [num_req_p-1:0]               req_w_i,
  input  logic [num_req_p*addr_width_lp-1:0] req_addr_i,
  input  logic [num_req_p*width_p-1:0]       req_data_i,
  input  logic [num_req_p*width_p-1:0]       req_mask_i,
  output logic                               resp_v_o,
  output logic [id_width_lp-1:0]             resp_id_o,
  output logic [width_p-1:0]                 resp_data_o,
  input  logic                               resp_ready_i,
  output logic                               init_done_o,
  output logic                               mem_v_o,
  output logic                               mem_w_o,
  output logic [addr_width_lp-1:0]           mem_addr_o,
  output logic [width_p-1:0]                 mem_data_o,
  output logic [width_p-1:0]                 mem_w_mask_o,
  input  logic [width_p-1:0]                 mem_data_i
);

  localparam state_e reset_state_lp = (init_p != 0) ? eINIT : eRUN;
  localparam logic [addr_width_lp-1:0] sweep_last_lp = addr_width_lp'(els_p - 1);

  state_e                          state_r, state_n;
  logic [addr_width_lp-1:0]        sweep_r;
  logic [id_width_lp-1:0]          rr_r, rr_n;
  logic                            inflight_r;
  logic [id_width_lp-1:0]          inflight_id_r;
  logic [1:0]                      cnt_r, cnt_eff;
  logic                            fifo_v, fifo_ready, deq;
  logic [id_width_lp+width_p-1:0]  fifo_data;
  logic [num_req_p-1:0]            elig, grant;
  logic                            grant_v, rd_grant;
  logic [id_width_lp-1:0]          win_id;
  int                              idx;
  logic                            g_w;
  logic [addr_width_lp-1:0]        g_addr;
  logic [width_p-1:0]              g_data, g_mask;
  logic                            m_v, m_w;
  logic [addr_width_lp-1:0]        m_addr;
  logic [width_p-1:0]              m_data, m_mask;

  // A dequeue in this cycle returns its credit immediately.
  assign deq      = fifo_v & resp_ready_i;
  assign cnt_eff  = cnt_r - {1'b0, deq};
  assign rd_grant = grant_v & ~g_w;

  // Eligibility and round-robin search starting at rr_r.
  always_comb begin
    elig    = '0;
    grant   = '0;
    grant_v = 1'b0;
    win_id  = '0;
    rr_n    = rr_r;
    idx     = 0;
    g_w     = 1'b0;
    g_addr  = '0;
    g_data  = '0;
    g_mask  = '0;
    if (state_r == eRUN) begin
      for (int i = 0; i < num_req_p; i++) begin
        elig[i] = req_v_i[i] & (req_w_i[i] | (cnt_eff < 2'd2));
      end
      for (int k = 0; k < num_req_p; k++) begin
        idx = (int'(rr_r) + k) % num_req_p;
        if (!grant_v && elig[idx]) begin
          grant_v    = 1'b1;
          grant[idx] = 1'b1;
          win_id     = id_width_lp'(idx);
          g_w        = req_w_i[idx];
          g_addr     = req_addr_i[idx*addr_width_lp +: addr_width_lp];
          g_data     = req_data_i[idx*width_p +: width_p];
          g_mask     = req_mask_i[idx*width_p +: width_p];
          rr_n       = (idx == num_req_p - 1) ? '0 : id_width_lp'(idx + 1);
        end
      end
    end
  end

  // RAM pin mux: sweep writes during eINIT, otherwise the winner's fields.
  always_comb begin
    m_v    = 1'b0;
    m_w    = 1'b0;
    m_addr = '0;
    m_data = '0;
    m_mask = '0;
    if (state_r == eINIT) begin
      m_v    = 1'b1;
      m_w    = 1'b1;
      m_addr = sweep_r;
      m_mask = '1;
    end else if (grant_v) begin
      m_v    = 1'b1;
      m_w    = g_w;
      m_addr = g_addr;
      m_data = g_data;
      m_mask = g_mask;
    end
  end

  // Next state: leave the sweep after the last word is written.
  always_comb begin
    state_n = state_r;
    if (state_r == eINIT && sweep_r == sweep_last_lp) begin
      state_n = eRUN;
    end
  end

  // State, sweep counter, rr pointer, credits and in-flight read tracking.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_r       <= reset_state_lp;
      sweep_r       <= '0;
      rr_r          <= '0;
      cnt_r         <= 2'd0;
      inflight_r    <= 1'b0;
      inflight_id_r <= '0;
    end else begin
      state_r    <= state_n;
      rr_r       <= rr_n;
      cnt_r      <= cnt_r + {1'b0, rd_grant} - {1'b0, deq};
      inflight_r <= rd_grant;
      if (state_r == eINIT) begin
        sweep_r <= sweep_r + 1'b1;
      end
      if (rd_grant) begin
        inflight_id_r <= win_id;
      end
    end
  end

  bsg_two_fifo #(.width_p(id_width_lp + width_p)) resp_fifo (
    .clk_i     (clk_i),
    .reset_n_i (reset_n_i),
    .v_i       (inflight_r),
    .data_i    ({inflight_id_r, mem_data_i}),
    .ready_o   (fifo_ready),
    .v_o       (fifo_v),
    .data_o    (fifo_data),
    .yumi_i    (deq)
  );

  // Every output is forced low while reset is held.
  assign req_ready_o  = reset_n_i ? grant : '0;
  assign init_done_o  = reset_n_i & (state_r == eRUN);
  assign mem_v_o      = reset_n_i & m_v;
  assign mem_w_o      = reset_n_i & m_w;
  assign mem_addr_o   = reset_n_i ? m_addr : '0;
  assign mem_data_o   = reset_n_i ? m_data : '0;
  assign mem_w_mask_o = reset_n_i ? m_mask : '0;
  assign resp_v_o     = reset_n_i & fifo_v;
  assign resp_id_o    = reset_n_i ? fifo_data[id_width_lp+width_p-1 -: id_width_lp] : '0;
  assign resp_data_o  = reset_n_i ? fifo_data[width_p-1:0] : '0;

`ifndef SYNTHESIS
  // Credits must guarantee room for every returning read.
  always_ff @(posedge clk_i) begin
    if (reset_n_i && inflight_r) begin
      assert (fifo_ready) else $error("response queue overflow");
    end
  end

  if (els_p < (1 << addr_width_lp)) begin : g_addr_chk
    // Out-of-range addresses hit undefined RAM words.
    always_ff @(posedge clk_i) begin
      if (reset_n_i && m_v) begin
        assert (int'(m_addr) < els_p) else $error("address %0d out of range", m_addr);
      end
    end
  end
`endif

endmodule
